// File: rtl/response_misr.sv
// -----------------------------------------------------------------------------
// response_misr
// Multiple-input signature register (x^25 + x^3 + 1) that compacts a stream of
// 25-bit circuit-under-test responses into a signature. It then compares the
// final signature against a golden value that is latched at start.
//
// Ports
//   clk          : rising-edge clock for all state
//   rst_n        : synchronous active-low reset
//   enable       : global advance qualifier; when low, all state holds
//   start        : single-cycle pulse that begins a run (honoured in IDLE/DONE)
//   num_vectors  : number of responses to compact (sampled on accepted start)
//   golden_sig   : expected final signature (sampled on accepted start)
//   resp_in      : 25-bit response word
//   resp_valid   : qualifies resp_in this cycle
//   signature    : current MISR contents
//   vec_count    : responses accepted in the current run
//   busy         : high while in RUN
//   done         : high while in DONE
//   match        : signature == golden, valid while done is high
// -----------------------------------------------------------------------------
module response_misr #(
  parameter logic [24:0] SEED = 25'h0000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        start,
  input  logic [15:0] num_vectors,
  input  logic [24:0] golden_sig,
  input  logic [24:0] resp_in,
  input  logic        resp_valid,
  output logic [24:0] signature,
  output logic [15:0] vec_count,
  output logic        busy,
  output logic        done,
  output logic        match
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [24:0] r_sig;
  logic [15:0] r_cnt;
  logic [15:0] r_num;
  logic [24:0] r_golden;
  logic        r_busy;
  logic        r_done;
  logic        r_match;

  logic [24:0] w_next;
  logic [15:0] w_cnt_inc;
  logic        w_last;

  // MISR next state: each stage takes the previous stage, bit 0 takes the
  // feedback tap s[24], and bit 3 also mixes in the feedback for the x^3 term.
  genvar gi;
  generate
    for (gi = 0; gi < 25; gi = gi + 1) begin : g_misr
      if (gi == 0) begin : g_b0
        assign w_next[gi] = r_sig[24] ^ resp_in[gi];
      end else if (gi == 3) begin : g_b3
        assign w_next[gi] = r_sig[gi-1] ^ r_sig[24] ^ resp_in[gi];
      end else begin : g_bn
        assign w_next[gi] = r_sig[gi-1] ^ resp_in[gi];
      end
    end
  endgenerate

  // vec_count < r_num whenever in RUN, so the increment cannot wrap there.
  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_last    = (w_cnt_inc == r_num);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sig    <= '0;
      r_cnt    <= '0;
      r_num    <= '0;
      r_golden <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_match  <= 1'b0;
    end else if (enable) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_sig    <= SEED;
            r_cnt    <= '0;
            r_num    <= num_vectors;
            r_golden <= golden_sig;
            if (num_vectors == 16'd0) begin
              // Empty run: the seed itself is the final signature.
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_match <= (SEED == golden_sig);
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_match <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (resp_valid) begin
            r_sig <= w_next;
            r_cnt <= w_cnt_inc;
            if (w_last) begin
              // Compare the post-update signature so match lines up with done.
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_match <= (w_next == r_golden);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign signature = r_sig;
  assign vec_count = r_cnt;
  assign busy      = r_busy;
  assign done      = r_done;
  assign match     = r_match;

endmodule

// File: tb/tb_response_misr.sv
// -----------------------------------------------------------------------------
// tb_response_misr
// Self-checking bench for response_misr. Two instances are used: one with the
// default seed and one with seed 25'h1000000 for the feedback-wrap case.
// Single-run cases are table driven; multi-cycle corners are hand sequences.
// -----------------------------------------------------------------------------
module tb_response_misr;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        start;
  logic [15:0] num_vectors;
  logic [24:0] golden_sig;
  logic [24:0] resp_in;
  logic        resp_valid;

  logic [24:0] sig_a, sig_b;
  logic [15:0] cnt_a, cnt_b;
  logic        busy_a, busy_b, done_a, done_b, match_a, match_b;

  logic        sel_b;
  logic [24:0] sig;
  logic [15:0] cnt;
  logic        busy, done, match;

  int errors = 0;
  int checks = 0;

  response_misr #(.SEED(25'h0000001)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .num_vectors(num_vectors), .golden_sig(golden_sig),
    .resp_in(resp_in), .resp_valid(resp_valid),
    .signature(sig_a), .vec_count(cnt_a), .busy(busy_a), .done(done_a),
    .match(match_a)
  );

  response_misr #(.SEED(25'h1000000)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .num_vectors(num_vectors), .golden_sig(golden_sig),
    .resp_in(resp_in), .resp_valid(resp_valid),
    .signature(sig_b), .vec_count(cnt_b), .busy(busy_b), .done(done_b),
    .match(match_b)
  );

  assign sig   = sel_b ? sig_b   : sig_a;
  assign cnt   = sel_b ? cnt_b   : cnt_a;
  assign busy  = sel_b ? busy_b  : busy_a;
  assign done  = sel_b ? done_b  : done_a;
  assign match = sel_b ? match_b : match_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             sel_b;
    logic [15:0]      num;
    logic [24:0]      golden;
    logic [2:0][24:0] resp;
    logic [24:0]      exp_sig;
    logic [15:0]      exp_cnt;
    logic             exp_match;
  } vec_t;

  vec_t tbl[6];

  // Independent bit-level reference of the polynomial update.
  function automatic logic [24:0] misr_model(input logic [24:0] s, input logic [24:0] r);
    logic [24:0] n;
    for (int i = 0; i < 25; i++) begin
      if (i == 0)      n[i] = s[24] ^ r[0];
      else if (i == 3) n[i] = s[2] ^ s[24] ^ r[3];
      else             n[i] = s[i-1] ^ r[i];
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic run_case(input int idx);
    vec_t v;
    v = tbl[idx];
    sel_b       = v.sel_b;
    start       = 1'b1;
    num_vectors = v.num;
    golden_sig  = v.golden;
    step();
    start = 1'b0;
    if (v.num != 16'd0) begin
      chk($sformatf("case%0d busy after start", idx), {31'd0, busy}, 32'd1);
      chk($sformatf("case%0d seed load", idx), {7'd0, sig},
          v.sel_b ? 32'h1000000 : 32'h1);
      for (int j = 0; j < int'(v.num); j++) begin
        resp_in    = v.resp[j];
        resp_valid = 1'b1;
        if (j == int'(v.num) - 1)
          chk($sformatf("case%0d done low before last edge", idx), {31'd0, done}, 32'd0);
        step();
      end
      resp_valid = 1'b0;
      resp_in    = '0;
    end
    chk($sformatf("case%0d done", idx), {31'd0, done}, 32'd1);
    chk($sformatf("case%0d busy", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("case%0d signature", idx), {7'd0, sig}, {7'd0, v.exp_sig});
    chk($sformatf("case%0d vec_count", idx), {16'd0, cnt}, {16'd0, v.exp_cnt});
    chk($sformatf("case%0d match", idx), {31'd0, match}, {31'd0, v.exp_match});
  endtask

  initial begin
    logic [24:0] model;
    logic [24:0] rv;
    logic [24:0] snap_sig;
    logic [15:0] snap_cnt;

    //          sel  num    golden        resp[2], resp[1], resp[0]                 sig          cnt  match
    tbl[0] = '{1'b0, 16'd1, 25'h0000002, {25'h0, 25'h0, 25'h0},                     25'h0000002, 16'd1, 1'b1};
    tbl[1] = '{1'b0, 16'd3, 25'h0000008, {25'h0, 25'h0, 25'h0},                     25'h0000008, 16'd3, 1'b1};
    tbl[2] = '{1'b1, 16'd1, 25'h0000000, {25'h0, 25'h0, 25'h0},                     25'h0000009, 16'd1, 1'b0};
    tbl[3] = '{1'b0, 16'd1, 25'h0000000, {25'h0, 25'h0, 25'h0000001},               25'h0000003, 16'd1, 1'b0};
    tbl[4] = '{1'b0, 16'd2, 25'h1FFFFF3, {25'h0, 25'h0, 25'h1FFFFFF},               25'h1FFFFF3, 16'd2, 1'b1};
    tbl[5] = '{1'b0, 16'd0, 25'h0000001, {25'h0, 25'h0, 25'h0},                     25'h0000001, 16'd0, 1'b1};

    sel_b = 1'b0; rst_n = 1'b0; enable = 1'b1; start = 1'b0;
    num_vectors = '0; golden_sig = '0; resp_in = '0; resp_valid = 1'b0;
    step(); step();
    chk("reset signature", {7'd0, sig}, 32'd0);
    chk("reset vec_count", {16'd0, cnt}, 32'd0);
    chk("reset busy/done/match", {29'd0, busy, done, match}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_case(i);
    sel_b = 1'b0;

    // Three zero responses with gaps in resp_valid.
    start = 1'b1; num_vectors = 16'd3; golden_sig = 25'h0000008;
    step(); start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      resp_valid = 1'b0; step(); step();
      chk($sformatf("gap count before accept %0d", j), {16'd0, cnt}, j);
      resp_valid = 1'b1; step();
    end
    resp_valid = 1'b0;
    chk("gap signature", {7'd0, sig}, 32'h8);
    chk("gap count", {16'd0, cnt}, 32'd3);
    chk("gap done/match", {30'd0, done, match}, 32'd3);

    // Extra valid responses in DONE are not accepted.
    resp_valid = 1'b1; resp_in = 25'h0ABCDEF; step(); step();
    resp_valid = 1'b0;
    chk("no accept in DONE count", {16'd0, cnt}, 32'd3);
    chk("no accept in DONE sig", {7'd0, sig}, 32'h8);

    // start in DONE begins a new run; start during RUN is ignored.
    start = 1'b1; num_vectors = 16'd3; golden_sig = 25'h0;
    step(); start = 1'b0;
    chk("restart seed", {7'd0, sig}, 32'h1);
    chk("restart count", {16'd0, cnt}, 32'd0);
    chk("restart busy/done", {30'd0, busy, done}, 32'd2);
    resp_in = 25'h0; resp_valid = 1'b1; step(); resp_valid = 1'b0;
    start = 1'b1; num_vectors = 16'd1; step(); start = 1'b0;
    chk("start in RUN sig", {7'd0, sig}, 32'h2);
    chk("start in RUN busy", {31'd0, busy}, 32'd1);

    // enable low for 4 cycles with resp_valid high: everything frozen.
    enable = 1'b0; resp_valid = 1'b1; resp_in = 25'h1234567;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("freeze sig %0d", j), {7'd0, sig}, 32'h2);
      chk($sformatf("freeze cnt %0d", j), {16'd0, cnt}, 32'd1);
      chk($sformatf("freeze busy/done %0d", j), {30'd0, busy, done}, 32'd2);
    end
    enable = 1'b1; resp_in = 25'h0; step();
    chk("after freeze cnt", {16'd0, cnt}, 32'd2);
    chk("after freeze sig", {7'd0, sig}, 32'h4);

    // Reset mid-run aborts without done.
    rst_n = 1'b0; start = 1'b1; step();
    rst_n = 1'b1; start = 1'b0; resp_valid = 1'b0;
    chk("midrun reset sig", {7'd0, sig}, 32'd0);
    chk("midrun reset cnt", {16'd0, cnt}, 32'd0);
    chk("midrun reset flags", {29'd0, busy, done, match}, 32'd0);
    step();
    chk("idle after reset", {30'd0, busy, done}, 32'd0);

    // Maximum count: 65535 accepts with no wrap.
    model = 25'h0000001;
    start = 1'b1; num_vectors = 16'hFFFF; golden_sig = 25'h0;
    step(); start = 1'b0;
    resp_valid = 1'b1;
    for (int j = 0; j < 65535; j++) begin
      rv = 25'($urandom);
      resp_in = rv;
      model = misr_model(model, rv);
      step();
    end
    resp_valid = 1'b0;
    chk("max run count", {16'd0, cnt}, 32'hFFFF);
    chk("max run done", {31'd0, done}, 32'd1);
    chk("max run signature", {7'd0, sig}, {7'd0, model});
    snap_sig = sig; snap_cnt = cnt;
    resp_valid = 1'b1; step(); resp_valid = 1'b0;
    chk("max run hold count", {16'd0, cnt}, {16'd0, snap_cnt});
    chk("max run hold sig", {7'd0, sig}, {7'd0, snap_sig});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
